// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: state encoding and default widths shared by the
// countdown timer top level and its prescaler.
package countdown_timer_pkg;

    // Default widths of the counter and of the prescale field
    localparam int DefaultSize          = 5;
    localparam int DefaultPrescaleWidth = 4;

    // State encoding constants
    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ARMED  = 2'd1;
    localparam logic [1:0] STATE_RUN    = 2'd2;
    localparam logic [1:0] STATE_PAUSED = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = STATE_IDLE,
        ARMED  = STATE_ARMED,
        RUN    = STATE_RUN,
        PAUSED = STATE_PAUSED
    } state_t;

endpackage

// File: rtl/countdown_prescaler.sv
// countdown_prescaler: phase counter that emits a tick every prescale+1
// unfrozen cycles. The prescale value and a phase clear are taken on load.
module countdown_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int PrescaleWidth = DefaultPrescaleWidth
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic [PrescaleWidth-1:0] load_prescale,
    input  logic                     freeze,
    output logic                     tick
);

    logic [PrescaleWidth-1:0] prescale_reg;
    logic [PrescaleWidth-1:0] phase;

    // A tick is the last phase of a prescale period while running
    assign tick = !freeze && (phase == prescale_reg);

    // Capture the prescale on load; otherwise advance the phase unless frozen
    always_ff @(posedge clock) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            prescale_reg <= '0;
            phase        <= '0;
        end else if (load) begin
            prescale_reg <= load_prescale;
            phase        <= '0;
        end else if (!freeze) begin
            phase <= tick ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down counter with a prescaler, start/pause
// control and a one-cycle expired pulse when the count reaches zero.
// Optional feature macro: COUNTDOWN_TIMER_AUTORELOAD_EN -- reload the loaded
// value at every terminal tick and keep running instead of returning to IDLE.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int Size          = DefaultSize,
    parameter int PrescaleWidth = DefaultPrescaleWidth
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [Size-1:0]          load_value,
    input  logic [PrescaleWidth-1:0] load_prescale,
    input  logic                     start,
    input  logic                     pause,
    output logic [Size-1:0]          count,
    output logic                     busy,
    output logic                     expired
);

    state_t state;
    logic   load_accept;
    logic   freeze;
    logic   tick;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [Size-1:0] reload_value;
`endif

    // Loads are only taken while the timer is not counting
    assign load_ready  = (state == IDLE) || (state == ARMED);
    assign load_accept = load_valid && load_ready;

    // The prescaler only advances while counting and not held by pause
    assign freeze = pause || !((state == RUN) || (state == PAUSED));

    countdown_prescaler #(
        .PrescaleWidth(PrescaleWidth)
    ) u_prescaler (
        .clock        (clock),
        .reset        (reset),
        .load         (load_accept),
        .load_prescale(load_prescale),
        .freeze       (freeze),
        .tick         (tick)
    );

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    // Remember the loaded value so every terminal tick can restart from it
    always_ff @(posedge clock) begin
        if (reset) begin
            reload_value <= '0;
        end else if (load_accept) begin
            reload_value <= load_value;
        end
    end
`endif

    // Control FSM with registered count, busy and expired outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            busy    <= 1'b0;
            expired <= 1'b0;
        end else begin
            // NOTE: expired defaults low each edge so it is a single-cycle pulse.
            expired <= 1'b0;
            case (state)
                IDLE, ARMED: begin
                    if (load_valid) begin
                        // A load always wins over a coincident start
                        count <= load_value;
                        busy  <= 1'b0;
                        if (load_value == '0) begin
                            expired <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            state <= ARMED;
                        end
                    end else if ((state == ARMED) && start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN, PAUSED: begin
                    if (pause) begin
                        state <= PAUSED;
                    end else begin
                        // Leaving PAUSED resumes counting on the same edge
                        state <= RUN;
                        if (tick) begin
                            if (count > Size'(1)) begin
                                count <= count - 1'b1;
                            end else begin
                                expired <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                                count   <= reload_value;
`else
                                count   <= '0;
                                state   <= IDLE;
                                busy    <= 1'b0;
`endif
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer.
// Inputs change just after the falling edge; outputs are checked there too.
module tb_countdown_timer;

    localparam int Size          = 5;
    localparam int PrescaleWidth = 4;

    logic                     clock;
    logic                     reset;
    logic                     load_valid;
    logic                     load_ready;
    logic [Size-1:0]          load_value;
    logic [PrescaleWidth-1:0] load_prescale;
    logic                     start;
    logic                     pause;
    logic [Size-1:0]          count;
    logic                     busy;
    logic                     expired;

    int errors = 0;
    int checks = 0;

    countdown_timer #(
        .Size         (Size),
        .PrescaleWidth(PrescaleWidth)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_value   (load_value),
        .load_prescale(load_prescale),
        .start        (start),
        .pause        (pause),
        .count        (count),
        .busy         (busy),
        .expired      (expired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance through one rising edge and stop at the following falling edge
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Present one load for a single edge
    task automatic do_load(input logic [Size-1:0] value, input logic [PrescaleWidth-1:0] prescale);
        load_valid    = 1'b1;
        load_value    = value;
        load_prescale = prescale;
        step();
        load_valid = 1'b0;
    endtask

    // Present start for a single edge; returns in cycle 1 after the start edge
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        load_valid    = 1'b0;
        load_value    = '0;
        load_prescale = '0;
        start         = 1'b0;
        pause         = 1'b0;
        @(negedge clock);
        step();
        step();
        reset = 1'b0;

        // Reset then idle, with a stray start that must be ignored
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("idle_count", 32'(count), 32'd0);
            check("idle_load_ready", 32'(load_ready), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_expired", 32'(expired), 32'd0);
            step();
        end
        start = 1'b0;

        // Load 3, P 0: count 3,2,1,0 with expiry in cycle 4
        do_load(5'd3, 4'd0);
        check("p0_armed_count", 32'(count), 32'd3);
        check("p0_armed_ready", 32'(load_ready), 32'd1);
        do_start();
        for (int k = 1; k <= 5; k++) begin
            check("p0_count", 32'(count), (k <= 3) ? 32'(4 - k) : 32'd0);
            check("p0_expired", 32'(expired), (k == 4) ? 32'd1 : 32'd0);
            check("p0_busy", 32'(busy), (k <= 3) ? 32'd1 : 32'd0);
            check("p0_load_ready", 32'(load_ready), (k <= 3) ? 32'd0 : 32'd1);
            step();
        end

        // Load 2, P 2: expiry 7 cycles after start, count changes every 3
        do_load(5'd2, 4'd2);
        do_start();
        for (int k = 1; k <= 8; k++) begin
            check("p2_count", 32'(count), (k <= 3) ? 32'd2 : ((k <= 6) ? 32'd1 : 32'd0));
            check("p2_expired", 32'(expired), (k == 7) ? 32'd1 : 32'd0);
            step();
        end

        // Load 5, P 0, pause 4 cycles at count 3: expiry moves from cycle 6 to 10
        do_load(5'd5, 4'd0);
        do_start();
        check("pause_c1", 32'(count), 32'd5);
        step();
        check("pause_c2", 32'(count), 32'd4);
        check("run_load_ready", 32'(load_ready), 32'd0);
        load_valid = 1'b1;
        load_value = 5'd17;
        step();
        load_valid = 1'b0;
        check("pause_c3", 32'(count), 32'd3);
        pause = 1'b1;
        for (int k = 4; k <= 7; k++) begin
            step();
            check("paused_count", 32'(count), 32'd3);
            check("paused_busy", 32'(busy), 32'd1);
            check("paused_expired", 32'(expired), 32'd0);
        end
        pause = 1'b0;
        for (int k = 8; k <= 11; k++) begin
            step();
            check("resume_count", 32'(count), (k <= 9) ? 32'(10 - k) : 32'd0);
            check("resume_expired", 32'(expired), (k == 10) ? 32'd1 : 32'd0);
        end

        // Load while ARMED with a coincident start: load wins, no counting
        do_load(5'd7, 4'd0);
        start = 1'b1;
        do_load(5'd9, 4'd0);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("armed_reload_count", 32'(count), 32'd9);
            check("armed_reload_ready", 32'(load_ready), 32'd1);
            check("armed_reload_busy", 32'(busy), 32'd0);
            step();
        end

        // Run from 9 and reset at count 4: abort with no expiry
        do_start();
        for (int k = 1; k <= 5; k++) begin
            check("abort_count", 32'(count), 32'(10 - k));
            step();
        end
        check("abort_at4", 32'(count), 32'd4);
        reset      = 1'b1;
        load_valid = 1'b1;
        load_value = 5'd12;
        step();
        reset      = 1'b0;
        load_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("abort_count_zero", 32'(count), 32'd0);
            check("abort_expired", 32'(expired), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_ready", 32'(load_ready), 32'd1);
            step();
        end

        // Load 0: immediate expiry pulse and back in IDLE
        do_load(5'd0, 4'd3);
        check("zero_expired", 32'(expired), 32'd1);
        check("zero_count", 32'(count), 32'd0);
        check("zero_ready", 32'(load_ready), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_expired_gone", 32'(expired), 32'd0);
        check("zero_idle_busy", 32'(busy), 32'd0);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        // Auto-reload: load 2, P 0 counts 2,1,2,1 with expiry at each reload
        do_load(5'd2, 4'd0);
        do_start();
        for (int k = 1; k <= 7; k++) begin
            check("ar_count", 32'(count), (k % 2 == 1) ? 32'd2 : 32'd1);
            check("ar_expired", 32'(expired), ((k % 2 == 1) && (k > 1)) ? 32'd1 : 32'd0);
            check("ar_busy", 32'(busy), 32'd1);
            check("ar_ready", 32'(load_ready), 32'd0);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ar_reset_count", 32'(count), 32'd0);
        check("ar_reset_ready", 32'(load_ready), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
